// File: rtl/call_stack.sv
// Parametrised return stack for the control unit: saves return PC and flags on CALL, restores on RET.
// Supports push+pop as an in-place top replacement (tail call) and sticky overflow/underflow errors.
module call_stack #(
    parameter int PC_W   = 9,
    parameter int FLAG_W = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_en,
    input  logic              pop_en,
    input  logic              clr_err,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [FLAG_W-1:0] in_flags,
    output logic [PC_W-1:0]   out_pc,
    output logic [FLAG_W-1:0] out_flags,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = PC_W + FLAG_W;

    logic [ENT_W-1:0] entry_reg [DEPTH];
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             overflow_reg;
    logic             underflow_reg;

    logic             is_empty;
    logic             is_full;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;
    logic [ENT_W-1:0] wr_data;
    logic [DEPTH-1:0] entry_we;
    logic             set_ovf;
    logic             set_unf;

    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == CNT_W'(DEPTH));
    assign top_idx  = IDX_W'(count_reg - CNT_W'(1));
    assign wr_data  = {in_pc + PC_W'(1), in_flags};

    always_comb begin
        wr_en      = 1'b0;
        wr_idx     = IDX_W'(count_reg);
        count_next = count_reg;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        case ({push_en, pop_en})
            2'b10: begin
                if (is_full) begin
                    set_ovf = 1'b1;
                end else begin
                    wr_en      = 1'b1;
                    count_next = count_reg + CNT_W'(1);
                end
            end
            2'b01: begin
                if (is_empty) begin
                    set_unf = 1'b1;
                end else begin
                    count_next = count_reg - CNT_W'(1);
                end
            end
            2'b11: begin
                // Tail call: overwrite the top in place; on an empty stack it degenerates to a push.
                wr_en = 1'b1;
                if (is_empty) begin
                    count_next = CNT_W'(1);
                end else begin
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign entry_we[gi] = wr_en && (wr_idx == IDX_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_we[i]) begin
                    entry_reg[i] <= wr_data;
                end
            end
        end
    end

    // A new error event at the same edge as clr_err leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            overflow_reg  <= set_ovf | (overflow_reg & ~clr_err);
            underflow_reg <= set_unf | (underflow_reg & ~clr_err);
        end
    end

    assign {out_pc, out_flags} = is_empty ? '0 : entry_reg[top_idx];
    assign count     = count_reg;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: directed scenarios plus randomized traffic, checked against a queue-based model.
module tb_call_stack;

    localparam int PC_W   = 9;
    localparam int FLAG_W = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ST_W   = PC_W + FLAG_W + CNT_W + 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              push_en = 1'b0;
    logic              pop_en = 1'b0;
    logic              clr_err = 1'b0;
    logic [PC_W-1:0]   in_pc = '0;
    logic [FLAG_W-1:0] in_flags = '0;
    logic [PC_W-1:0]   out_pc;
    logic [FLAG_W-1:0] out_flags;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    call_stack #(.PC_W(PC_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .push_en(push_en), .pop_en(pop_en), .clr_err(clr_err),
        .in_pc(in_pc), .in_flags(in_flags), .out_pc(out_pc), .out_flags(out_flags),
        .count(count), .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of saved return addresses / flags plus two error bits.
    logic [PC_W-1:0]   m_pc [$];
    logic [FLAG_W-1:0] m_fl [$];
    logic              m_ovf;
    logic              m_unf;

    int checks = 0;
    int fails  = 0;

    logic [ST_W-1:0] got;
    logic [ST_W-1:0] want;

    function automatic void model_reset();
        m_pc.delete();
        m_fl.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic void model_step(input logic push, input logic pop, input logic clr,
                                       input logic [PC_W-1:0] pc, input logic [FLAG_W-1:0] fl);
        logic new_ovf = 1'b0;
        logic new_unf = 1'b0;
        int   n = m_pc.size();
        logic [PC_W-1:0] ret = pc + 1'b1;
        if (push && pop) begin
            if (n == 0) begin
                m_pc.push_back(ret);
                m_fl.push_back(fl);
            end else begin
                m_pc[n-1] = ret;
                m_fl[n-1] = fl;
            end
        end else if (push) begin
            if (n == DEPTH) new_ovf = 1'b1;
            else begin
                m_pc.push_back(ret);
                m_fl.push_back(fl);
            end
        end else if (pop) begin
            if (n == 0) new_unf = 1'b1;
            else begin
                void'(m_pc.pop_back());
                void'(m_fl.pop_back());
            end
        end
        m_ovf = new_ovf | (m_ovf & ~clr);
        m_unf = new_unf | (m_unf & ~clr);
    endfunction

    function automatic logic [ST_W-1:0] model_status();
        int n = m_pc.size();
        logic [PC_W-1:0]   p = '0;
        logic [FLAG_W-1:0] f = '0;
        if (n > 0) begin
            p = m_pc[n-1];
            f = m_fl[n-1];
        end
        return {p, f, CNT_W'(n), (n == 0), (n == DEPTH), m_ovf, m_unf};
    endfunction

    task automatic sample();
        got  = {out_pc, out_flags, count, empty, full, overflow, underflow};
        want = model_status();
    endtask

    // Drive one clock of stimulus; data is X whenever no write is requested.
    task automatic do_op(input logic push, input logic pop, input logic clr,
                         input logic [PC_W-1:0] pc, input logic [FLAG_W-1:0] fl);
        @(negedge clk);
        push_en  = push;
        pop_en   = pop;
        clr_err  = clr;
        in_pc    = push ? pc : 'x;
        in_flags = push ? fl : 'x;
        @(posedge clk);
        model_step(push, pop, clr, pc, fl);
        #1;
        push_en  = 1'b0;
        pop_en   = 1'b0;
        clr_err  = 1'b0;
        in_pc    = 'x;
        in_flags = 'x;
        sample();
        $display("op push=%0d pop=%0d clr=%0d pc=%h fl=%h -> out_pc=%h out_fl=%h cnt=%0d ovf=%0d unf=%0d",
                 push, pop, clr, pc, fl, out_pc, out_flags, count, overflow, underflow);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        sample();
        checks++;
        if (got !== want || got !== ST_W'(8)) begin
            fails++;
            $display("FAIL reset_state got=%h want=%h", got, want);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_push_pop();
        apply_reset();
        for (int i = 1; i <= 3; i++) begin
            do_op(1'b1, 1'b0, 1'b0, PC_W'(10 * i), FLAG_W'(i));
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL push_%0d got=%h want=%h", i, got, want);
            end
        end
        checks++;
        if (out_pc !== PC_W'(31) || out_flags !== 4'd3 || count !== CNT_W'(3)) begin
            fails++;
            $display("FAIL push3_top got pc=%0d fl=%0d cnt=%0d want pc=31 fl=3 cnt=3",
                     out_pc, out_flags, count);
        end
        for (int i = 1; i <= 3; i++) begin
            do_op(1'b0, 1'b1, 1'b0, '0, '0);
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL pop_%0d got=%h want=%h", i, got, want);
            end
        end
        checks++;
        if (out_pc !== '0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL pop_to_empty got pc=%0d empty=%0d want pc=0 empty=1", out_pc, empty);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i <= 8; i++) begin
            do_op(1'b1, 1'b0, 1'b0, PC_W'(i), FLAG_W'(i));
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL fill_%0d got=%h want=%h", i, got, want);
            end
        end
        checks++;
        if (full !== 1'b1 || overflow !== 1'b1 || out_pc !== PC_W'(8) || count !== CNT_W'(8)) begin
            fails++;
            $display("FAIL overflow_state got full=%0d ovf=%0d pc=%0d cnt=%0d want 1 1 8 8",
                     full, overflow, out_pc, count);
        end
        do_op(1'b0, 1'b1, 1'b0, '0, '0);
        checks++;
        if (got !== want || out_pc !== PC_W'(7) || overflow !== 1'b1) begin
            fails++;
            $display("FAIL pop_after_ovf got=%h want=%h", got, want);
        end
        do_op(1'b0, 1'b0, 1'b1, '0, '0);
        checks++;
        if (got !== want || overflow !== 1'b0) begin
            fails++;
            $display("FAIL clr_ovf got=%h want=%h", got, want);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        do_op(1'b0, 1'b1, 1'b0, '0, '0);
        checks++;
        if (got !== want || underflow !== 1'b1 || count !== '0) begin
            fails++;
            $display("FAIL pop_empty got=%h want=%h", got, want);
        end
        do_op(1'b0, 1'b0, 1'b1, '0, '0);
        do_op(1'b0, 1'b1, 1'b1, '0, '0);
        checks++;
        if (got !== want || underflow !== 1'b1) begin
            fails++;
            $display("FAIL set_beats_clr got=%h want=%h", got, want);
        end
    endtask

    task automatic test_replace();
        apply_reset();
        do_op(1'b1, 1'b0, 1'b0, PC_W'('h010), 4'h1);
        do_op(1'b1, 1'b0, 1'b0, PC_W'('h030), 4'h2);
        do_op(1'b1, 1'b1, 1'b0, PC_W'('h0FF), 4'hA);
        checks++;
        if (got !== want || out_pc !== PC_W'('h100) || out_flags !== 4'hA || count !== CNT_W'(2)) begin
            fails++;
            $display("FAIL replace_mid got=%h want=%h", got, want);
        end
        apply_reset();
        do_op(1'b1, 1'b1, 1'b0, PC_W'('h0FF), 4'hA);
        checks++;
        if (got !== want || count !== CNT_W'(1) || underflow !== 1'b0) begin
            fails++;
            $display("FAIL replace_empty got=%h want=%h", got, want);
        end
        for (int i = 0; i < DEPTH - 1; i++) do_op(1'b1, 1'b0, 1'b0, PC_W'(i), FLAG_W'(i));
        do_op(1'b1, 1'b1, 1'b0, PC_W'('h055), 4'h6);
        checks++;
        if (got !== want || overflow !== 1'b0 || count !== CNT_W'(DEPTH)) begin
            fails++;
            $display("FAIL replace_full got=%h want=%h", got, want);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        do_op(1'b1, 1'b0, 1'b0, PC_W'(511), 4'h5);
        checks++;
        if (got !== want || out_pc !== '0 || count !== CNT_W'(1)) begin
            fails++;
            $display("FAIL pc_wrap got=%h want=%h", got, want);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 1'b0, PC_W'(40 + i), FLAG_W'(i));
        do_op(1'b0, 1'b1, 1'b0, '0, '0);
        do_op(1'b0, 1'b1, 1'b0, '0, '0);
        do_op(1'b0, 1'b1, 1'b0, '0, '0);
        do_op(1'b0, 1'b1, 1'b0, '0, '0);
        do_op(1'b0, 1'b1, 1'b0, '0, '0);
        do_op(1'b0, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 1'b0, PC_W'(60 + i), FLAG_W'(i));
        @(negedge clk);
        push_en  = 1'b1;
        in_pc    = PC_W'(99);
        in_flags = 4'h9;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        sample();
        checks++;
        if (got !== want || count !== '0 || empty !== 1'b1 || underflow !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got=%h want=%h", got, want);
        end
        @(posedge clk);
        #1;
        push_en = 1'b0;
        sample();
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL reset_hold got=%h want=%h", got, want);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int pp;
        int pq;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            pp = (i < 100) ? 70 : ((i < 200) ? 30 : 50);
            pq = (i < 100) ? 30 : ((i < 200) ? 70 : 50);
            do_op($urandom_range(0, 99) < pp, $urandom_range(0, 99) < pq, $urandom_range(0, 7) == 0,
                  PC_W'($urandom), FLAG_W'($urandom));
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL random_%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
